// File: rtl/quad_enc_gen_pkg.sv
// Shared constants for the quadrature encoder generator: state codes, mode codes and
// the forward A/B phase table with a next-phase helper.
package quad_enc_gen_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_CONT  = 1'b1;

    // Entries are {A, B}; index 0 is the 00 phase, forward walks upward.
    localparam logic [3:0][1:0] FWD_PHASE = {2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic dir);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (FWD_PHASE[i] == ab) idx = 2'(i);
        end
        return dir ? FWD_PHASE[idx - 2'd1] : FWD_PHASE[idx + 2'd1];
    endfunction

endpackage

// File: rtl/quad_enc_gen_ctrl_fsm.sv
// Moore controller for the quadrature generator: sequences load, countdown, step and done.
module quad_enc_gen_ctrl_fsm
    import quad_enc_gen_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic stop_i,
    input  logic skip_i,
    input  logic timer_zero_i,
    input  logic last_step_i,
    output logic load_o,
    output logic dec_o,
    output logic step_o,
    output logic run_o,
    output logic busy_o,
    output logic done_o
);

    logic [2:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = skip_i ? S_DONE : S_LOAD;
            S_LOAD:  state_d = stop_i ? S_DONE : S_COUNT;
            S_COUNT: begin
                if (stop_i)            state_d = S_DONE;
                else if (timer_zero_i) state_d = S_STEP;
            end
            // The step itself is performed by the datapath whichever way we leave.
            S_STEP:  state_d = (stop_i || last_step_i) ? S_DONE : S_COUNT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    assign load_o = (state_q == S_LOAD);
    assign dec_o  = (state_q == S_COUNT);
    assign step_o = (state_q == S_STEP);
    assign run_o  = (state_q == S_COUNT) || (state_q == S_STEP);
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

endmodule

// File: rtl/quad_enc_gen_multi.sv
// Quadrature A/B/index waveform generator with burst/continuous runs and a start/busy/done
// handshake. Define QUAD_ENC_GEN_INDEX_EN to include the pulse counter and index output.
module quad_enc_gen_multi
    import quad_enc_gen_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned STEP_CNT_W = 16,
    parameter int unsigned PPR_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic                  direction,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [STEP_CNT_W-1:0] step_target,
    input  logic [PPR_W-1:0]      pulses_per_rev,
    output logic                  quad_A,
    output logic                  quad_B,
    output logic                  quad_I,
    output logic [PPR_W-1:0]      pulse_count,
    output logic                  busy,
    output logic                  done
);

    logic load, dec, step, run, accept, skip, timer_zero, last_step;
    logic                  mode_q, mode_d, dir_q, dir_d;
    logic [PERIOD_W-1:0]   period_q, period_d, timer_q, timer_d;
    logic [STEP_CNT_W-1:0] rem_q, rem_d;
    logic [1:0]            ab_q, ab_d;

    assign accept     = start && !busy;
    assign skip       = (mode == MODE_BURST) && (step_target == '0);
    assign timer_zero = (timer_q == '0);
    assign last_step  = (mode_q == MODE_BURST) && (rem_q <= STEP_CNT_W'(1));

    quad_enc_gen_ctrl_fsm u_ctrl (
        .clk_i        (clk),
        .rst_ni       (reset),
        .start_i      (start),
        .stop_i       (stop),
        .skip_i       (skip),
        .timer_zero_i (timer_zero),
        .last_step_i  (last_step),
        .load_o       (load),
        .dec_o        (dec),
        .step_o       (step),
        .run_o        (run),
        .busy_o       (busy),
        .done_o       (done)
    );

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        period_d = period_q;
        rem_d    = rem_q;
        timer_d  = timer_q;
        ab_d     = ab_q;
        if (accept) begin
            mode_d   = mode;
            dir_d    = direction;
            period_d = period;
            rem_d    = step_target;
        end
        if (load || step) begin
            timer_d = period_q;
        end else if (dec && !timer_zero) begin
            timer_d = timer_q - PERIOD_W'(1);
        end
        if (step) begin
            ab_d = next_phase(ab_q, dir_q);
            if (rem_q != '0) rem_d = rem_q - STEP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_BURST;
            dir_q    <= 1'b0;
            period_q <= '0;
            timer_q  <= '0;
            rem_q    <= '0;
            ab_q     <= 2'b00;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            rem_q    <= rem_d;
            ab_q     <= ab_d;
        end
    end

    assign quad_A = ab_q[1];
    assign quad_B = ab_q[0];

`ifdef QUAD_ENC_GEN_INDEX_EN
    logic [PPR_W-1:0] ppr_q, ppr_d, cnt_q, cnt_d, ppr_eff;

    assign ppr_eff = (ppr_q == '0) ? PPR_W'(1) : ppr_q;

    always_comb begin
        ppr_d = accept ? pulses_per_rev : ppr_q;
        cnt_d = cnt_q;
        // Count moves only on the phase wrap through 00 (01->00 forward, 00->01 reverse).
        if (step && !dir_q && (ab_q == 2'b01)) begin
            cnt_d = (cnt_q >= ppr_eff - PPR_W'(1)) ? '0 : cnt_q + PPR_W'(1);
        end else if (step && dir_q && (ab_q == 2'b00)) begin
            cnt_d = (cnt_q == '0) ? ppr_eff - PPR_W'(1) : cnt_q - PPR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ppr_q <= '0;
            cnt_q <= '0;
        end else begin
            ppr_q <= ppr_d;
            cnt_q <= cnt_d;
        end
    end

    assign pulse_count = cnt_q;
    assign quad_I      = run && (ab_q == 2'b00) && (cnt_q == '0);
`else
    logic unused_idx;
    assign unused_idx  = ^{pulses_per_rev, run};
    assign pulse_count = '0;
    assign quad_I      = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_gen_multi.sv
// Self-checking bench for quad_enc_gen_multi: directed and random runs compared each cycle
// against a timeline model of steps, phase, index position and handshake.
module tb_quad_enc_gen_multi;

`ifdef QUAD_ENC_GEN_INDEX_EN
    localparam bit IndexEn = 1'b1;
`else
    localparam bit IndexEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop, mode, direction;
    logic [15:0] period, step_target;
    logic [11:0] ppr;
    logic        quad_A, quad_B, quad_I, busy, done;
    logic [11:0] pulse_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase index into {00,10,11,01}, position within revolution, effective ppr.
    logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int m_idx = 0;
    int m_pos = 0;
    int m_ppr = 1;

    quad_enc_gen_multi dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .mode           (mode),
        .direction      (direction),
        .period         (period),
        .step_target    (step_target),
        .pulses_per_rev (ppr),
        .quad_A         (quad_A),
        .quad_B         (quad_B),
        .quad_I         (quad_I),
        .pulse_count    (pulse_count),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_ab, input logic e_busy,
                             input logic e_done, input logic e_i, input int e_pc);
        chk({tag, ".ab"}, {30'd0, quad_A, quad_B}, {30'd0, e_ab});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, ".idx"}, {31'd0, quad_I}, {31'd0, e_i});
        chk({tag, ".pcnt"}, {20'd0, pulse_count}, 32'(e_pc));
    endtask

    task automatic model_step(input logic d);
        if (!d) begin
            if (m_idx == 3) m_pos = (m_pos + 1) % m_ppr;
            m_idx = (m_idx + 1) % 4;
        end else begin
            if (m_idx == 0) m_pos = (m_pos + m_ppr - 1) % m_ppr;
            m_idx = (m_idx + 3) % 4;
        end
    endtask

    task automatic garble();
        mode        = 1'($urandom);
        direction   = 1'($urandom);
        period      = 16'($urandom);
        step_target = 16'($urandom % 3);
        ppr         = 12'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_idx = 0;
        m_pos = 0;
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge. ts: stop cycle, tstart: ignored start cycle,
    // trst: reset cycle (-1 = none); t counts cycles after the accepting edge.
    task automatic run(input logic m, input logic d, input int p, input int n, input int ts,
                       input int tstart, input int trst, input int ppr_in, input string tag);
        int t_done, lim, k, applied;
        logic e_run, e_i;
        mode = m; direction = d; period = 16'(p); step_target = 16'(n); ppr = 12'(ppr_in);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        garble();
        m_ppr = (ppr_in == 0) ? 1 : ppr_in;
        if (m == 1'b0 && n == 0) t_done = 0;
        else if (ts >= 0)        t_done = ts + 1;
        else                     t_done = n * (p + 2) + 1;
        applied = 0;
        for (int t = 0; t <= t_done + 2; t++) begin
            lim = (t < t_done) ? t : t_done;
            k = (lim >= 1) ? (lim - 1) / (p + 2) : 0;
            if (m == 1'b0 && k > n) k = n;
            while (applied < k) begin
                model_step(d);
                applied++;
            end
            e_run = (t >= 1) && (t < t_done);
            e_i = IndexEn && e_run && (m_idx == 0) && (m_pos == 0);
            check_all(tag, tbl[m_idx], t <= t_done, t == t_done, e_i, IndexEn ? m_pos : 0);
            if (t == trst) begin
                reset = 1'b0;
                #1;
                check_all({tag, "_rst"}, 2'b00, 1'b0, 1'b0, 1'b0, 0);
                m_idx = 0;
                m_pos = 0;
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (t == ts) stop = 1'b1;
            if (t == tstart) begin
                garble();
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            stop  = 1'b0;
            start = 1'b0;
        end
    endtask

    initial begin
        int m, d, p, n, ts, tst, nat;
        reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; direction = 1'b0;
        period = '0; step_target = '0; ppr = '0;
        #3;
        check_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run(1'b0, 1'b0, 3, 10, -1, -1, 21, 3, "rst_mid");
        run(1'b0, 1'b0, 3, 8, -1, -1, -1, 3, "fwd_burst");
        run(1'b0, 1'b1, 0, 4, -1, -1, -1, 3, "rev_burst");
        run(1'b0, 1'b0, 2, 0, -1, -1, -1, 3, "zero_burst");
        run(1'b1, 1'b0, 4, 0, 3, 3, -1, 3, "cont_stop");
        run(1'b1, 1'b1, 2, 0, 9, 10, -1, 3, "cont_stop2");
        run(1'b0, 1'b0, 1, 3, -1, 2, -1, 3, "resume");

        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check_all("idle_stop", tbl[m_idx], 1'b0, 1'b0, 1'b0, IndexEn ? m_pos : 0);

        do_reset();
        run(1'b1, 1'b0, 1, 0, 48, -1, -1, 2, "index");

        for (int r = 0; r < 14; r++) begin
            m = int'($urandom % 2);
            d = int'($urandom % 2);
            p = int'($urandom % 5);
            n = int'($urandom % 7);
            if (m == 1) ts = int'($urandom_range(0, 30));
            else if (n > 0 && ($urandom % 3) == 0) ts = int'($urandom_range(0, n * (p + 2)));
            else ts = -1;
            if (m == 0 && n == 0) nat = 0;
            else if (ts >= 0)     nat = ts + 1;
            else                  nat = n * (p + 2) + 1;
            tst = ($urandom % 2 == 1) ? int'($urandom_range(0, nat)) : -1;
            run(1'(m), 1'(d), p, n, ts, tst, -1, 3, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
